haar_dwt_stage: RTL

Single-level Haar wavelet decomposition stage that sits directly downstream of the ADC-to-AXI-Stream converter. Takes the converter's 32-bit sample words (valid-only, no backpressure upstream), pairs consecutive samples, and emits one {detail, approx} word per pair. Output is AXI-Stream with `tready`, `tlast` framing and an internal FIFO. Overflow is sticky-flagged rather than stalling the ADC.

---
 rtl/haar_dwt_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/haar_dwt_stage.sv
// haar_dwt_stage
//   Single-level Haar wavelet stage fed by the ADC-to-AXI-Stream converter.
//   Consecutive input samples are paired as (even, odd). Each pair becomes one
//   output word {detail, approx}:
//     approx = floor((x_e + x_o) / 2)
//     detail = floor((x_e - x_o) / 2)
//   Results pass through a first-word-fall-through FIFO onto an AXI-Stream
//   master. The input side has no backpressure. If a result arrives while the
//   FIFO is full and no pop is happening in that cycle, the result is dropped
//   and a sticky overflow flag is set.
//
// Ports
//   clk            single clock
//   rst            synchronous, active-high reset
//   s_axis_tdata   converter word; the sample is the low DATA_WIDTH bits
//   s_axis_tvalid  a sample is present this cycle (always consumed)
//   m_axis_tdata   {detail, approx}, both signed DATA_WIDTH
//   m_axis_tvalid  FIFO not empty
//   m_axis_tready  downstream accept
//   m_axis_tlast   last pair of a frame of FRAME_LEN input samples
//   overflow       sticky; a pair was dropped because the FIFO was full
module haar_dwt_stage #(
    parameter int DATA_WIDTH       = 16,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FRAME_LEN        = 1024,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        overflow
);

    localparam int PAIRS = FRAME_LEN / 2;
    localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic {EVEN, ODD} phase_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] detail;
        logic [DATA_WIDTH-1:0] approx;
    } res_t;

    // ------------------------------------------------------------------
    // Pairing phase FSM
    // ------------------------------------------------------------------
    phase_t phase_q, phase_d;
    logic   pair_done;

    always_ff @(posedge clk) begin
        if (rst) phase_q <= EVEN;
        else     phase_q <= phase_d;
    end

    always_comb begin
        phase_d   = phase_q;
        pair_done = 1'b0;
        if (s_axis_tvalid) begin
            case (phase_q)
                EVEN: phase_d = ODD;
                ODD: begin
                    phase_d   = EVEN;
                    pair_done = 1'b1;
                end
                default: phase_d = EVEN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Haar arithmetic
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] x_e_q;
    logic [DATA_WIDTH-1:0] x_o;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [CW-1:0]         pair_cnt_q;
    logic                  frame_end;
    res_t                  res_d, res_q;
    logic                  res_vld_q;

    assign x_o = s_axis_tdata[DATA_WIDTH-1:0];

    // One extra bit of headroom. Dropping the LSB of the two's-complement
    // sum is the floor-halving, and the result always fits DATA_WIDTH.
    assign sum  = {x_e_q[DATA_WIDTH-1], x_e_q} + {x_o[DATA_WIDTH-1], x_o};
    assign diff = {x_e_q[DATA_WIDTH-1], x_e_q} - {x_o[DATA_WIDTH-1], x_o};

    assign frame_end = (pair_cnt_q == CW'(PAIRS - 1));

    always_comb begin
        res_d.approx = sum[DATA_WIDTH:1];
        res_d.detail = diff[DATA_WIDTH:1];
        res_d.last   = frame_end;
    end

    // The pair counter advances on every completed pair, including pairs
    // that are later dropped. This keeps tlast locked to the ADC sample
    // count rather than to the words that are actually delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_e_q      <= '0;
            pair_cnt_q <= '0;
            res_q      <= '0;
            res_vld_q  <= 1'b0;
        end else begin
            res_vld_q <= pair_done;
            if (s_axis_tvalid && phase_q == EVEN)
                x_e_q <= x_o;
            if (pair_done) begin
                res_q      <= res_d;
                pair_cnt_q <= frame_end ? '0 : pair_cnt_q + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    res_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          empty, full, push, pop, drop;
    logic          overflow_q;
    res_t          head;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = !empty && m_axis_tready;
    // A pop in the same cycle frees a slot, so a write into a full FIFO
    // still succeeds then.
    assign push  = res_vld_q && (!full || pop);
    assign drop  = res_vld_q && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr_q] <= res_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    // The head entry is gated by empty. This makes the outputs read zero
    // after reset, because the storage array itself is not cleared.
    assign head          = mem[rd_ptr_q];
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? '0 : AXIS_TDATA_WIDTH'({head.detail, head.approx});
    assign m_axis_tlast  = !empty && head.last;
    assign overflow      = overflow_q;

    // The upper lane of the converter word carries nothing for this stage.
    logic unused_upper;
    assign unused_upper = ^s_axis_tdata[AXIS_TDATA_WIDTH-1:DATA_WIDTH];

endmodule
